// File: rtl/tetris_pkg.sv
// Board geometry and clear-sequencer state encoding shared by the board logic.
package tetris_pkg;
    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int ROW_AW  = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CHK,
        S_WR,
        S_FILL,
        S_DONE
    } clr_state_t;
endpackage

// File: rtl/board_clear_ctrl.sv
// Line-clear sequencer: scans rows bottom-up, compacts surviving rows down,
// zero-fills the vacated top rows and tracks total lines and level.
module board_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [4:0]         lines_cleared,
    output logic [15:0]        total_lines,
    output logic [3:0]         level,
    output logic [ROW_AW-1:0]  row_addr,
    output logic               row_rd_en,
    input  logic [BOARD_W-1:0] row_rdata,
    output logic               row_wr_en,
    output logic [BOARD_W-1:0] row_wdata
);
    localparam int PW = (LINES_PER_LEVEL > 1) ? $clog2(LINES_PER_LEVEL) : 1;
    localparam logic [ROW_AW-1:0] BOTTOM = ROW_AW'(BOARD_H - 1);

    clr_state_t         state_q, state_d;
    logic [ROW_AW-1:0]  src_q, src_d, dst_q, dst_d;
    logic [4:0]         cleared_q, cleared_d;
    logic [PW-1:0]      prog_q, prog_d;
    logic [BOARD_W-1:0] buf_q, buf_d;
    logic [4:0]         lc_q, lc_d;
    logic [15:0]        total_q, total_d;
    logic [3:0]         level_q, level_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               rd_q, rd_d, wr_q, wr_d;
    logic [ROW_AW-1:0]  addr_q, addr_d;
    logic [BOARD_W-1:0] wdata_q, wdata_d;
    logic               last, pass_end;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cleared_d = cleared_q;
        prog_d    = prog_q;
        buf_d     = buf_q;
        lc_d      = lc_q;
        total_d   = total_q;
        level_d   = level_q;
        pass_end  = 1'b0;
        last      = (src_q == '0);

        case (state_q)
            S_IDLE: if (start) begin
                src_d     = BOTTOM;
                dst_d     = BOTTOM;
                cleared_d = '0;
                lc_d      = '0;
                state_d   = S_RD;
            end
            S_RD: state_d = S_CHK;
            S_CHK: begin
                if (&row_rdata) begin
                    cleared_d = cleared_q + 5'd1;
                    if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
                    if (prog_q == PW'(LINES_PER_LEVEL - 1)) begin
                        prog_d = '0;
                        if (level_q != 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
                    end else begin
                        prog_d = prog_q + PW'(1);
                    end
                    if (!last) src_d = src_q - 1'b1;
                    pass_end = last;
                    state_d  = S_RD;
                end else if (dst_q == src_q) begin
                    if (!last) begin
                        src_d = src_q - 1'b1;
                        dst_d = dst_q - 1'b1;
                    end
                    pass_end = last;
                    state_d  = S_RD;
                end else begin
                    buf_d   = row_rdata;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                // dst is strictly above src here, so it is at least 1
                dst_d = dst_q - 1'b1;
                if (!last) src_d = src_q - 1'b1;
                pass_end = last;
                state_d  = S_RD;
            end
            S_FILL: begin
                if (dst_q == '0) state_d = S_DONE;
                else             dst_d   = dst_q - 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Nothing to fill when no row was removed: skip straight to DONE
        if (pass_end) state_d = (cleared_d == '0) ? S_DONE : S_FILL;
        if (state_d == S_DONE) lc_d = cleared_d;

        // Outputs are decoded from the next state so they are registered
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        rd_d    = (state_d == S_RD);
        wr_d    = (state_d == S_WR) || (state_d == S_FILL);
        addr_d  = rd_d ? src_d : (wr_d ? dst_d : '0);
        wdata_d = (state_d == S_WR) ? buf_d : '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            cleared_q <= '0;
            prog_q    <= '0;
            buf_q     <= '0;
            lc_q      <= '0;
            total_q   <= '0;
            level_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cleared_q <= cleared_d;
            prog_q    <= prog_d;
            buf_q     <= buf_d;
            lc_q      <= lc_d;
            total_q   <= total_d;
            level_q   <= level_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_cleared = lc_q;
    assign total_lines   = total_q;
    assign level         = level_q;
    assign row_addr      = addr_q;
    assign row_rd_en     = rd_q;
    assign row_wr_en     = wr_q;
    assign row_wdata     = wdata_q;
endmodule

// File: tb/tb_board_clear_ctrl.sv
// Randomized bench for board_clear_ctrl against a row-list compaction model.
module tb_board_clear_ctrl;
    import tetris_pkg::*;

    localparam logic [BOARD_W-1:0] FULL = '1;

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b0;
    logic               start = 1'b0;
    logic               busy, done, row_rd_en, row_wr_en;
    logic [4:0]         lines_cleared;
    logic [15:0]        total_lines;
    logic [3:0]         level;
    logic [ROW_AW-1:0]  row_addr;
    logic [BOARD_W-1:0] row_rdata = '0;
    logic [BOARD_W-1:0] row_wdata;

    logic [BOARD_W-1:0] mem [BOARD_H];
    logic [BOARD_W-1:0] img [BOARD_H];
    logic [BOARD_W-1:0] exp_img [BOARD_H];
    logic               load_en = 1'b0;

    int checks = 0, failures = 0;
    int m_total = 0, m_cleared = 0, m_moved = 0;

    board_clear_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .total_lines(total_lines), .level(level),
        .row_addr(row_addr), .row_rd_en(row_rd_en), .row_rdata(row_rdata),
        .row_wr_en(row_wr_en), .row_wdata(row_wdata)
    );

    always #5 Clk = ~Clk;

    // Single-port row memory with one-cycle read latency
    always @(posedge Clk) begin
        if (load_en) mem <= img;
        else if (row_wr_en) mem[row_addr] <= row_wdata;
        if (row_rd_en) row_rdata <= mem[row_addr];
    end

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        if (obs != expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [BOARD_W-1:0] rand_row(input int pct_full);
        logic [BOARD_W-1:0] r;
        if (int'($urandom_range(99)) < pct_full) return FULL;
        r = BOARD_W'($urandom);
        if (r == FULL) r[0] = 1'b0;
        return r;
    endfunction

    task automatic load_board();
        @(negedge Clk); load_en = 1'b1;
        @(negedge Clk); load_en = 1'b0;
    endtask

    // Reference: keep non-full rows in bottom-up order, stack them at the bottom
    task automatic model_pass();
        int k;
        k = BOARD_H - 1;
        m_cleared = 0;
        m_moved = 0;
        for (int i = BOARD_H - 1; i >= 0; i--) begin
            if (img[i] == FULL) m_cleared++;
            else begin
                if (k != i) m_moved++;
                exp_img[k] = img[i];
                k--;
            end
        end
        for (int j = k; j >= 0; j--) exp_img[j] = '0;
        m_total = (m_total + m_cleared > 65535) ? 65535 : m_total + m_cleared;
    endtask

    task automatic run_pass(input string name, input bit hold_start);
        int cyc, dn, guard, lc, both;
        model_pass();
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); if (!hold_start) start = 1'b0;
        cyc = 0; dn = 0; guard = 0; lc = -1; both = 0;
        while (busy && guard < 400) begin
            cyc++;
            if (row_rd_en && row_wr_en) both++;
            if (done) begin dn++; lc = int'(lines_cleared); start = 1'b0; end
            @(negedge Clk);
            guard++;
        end
        start = 1'b0;
        chk({name, " timeout"}, guard < 400, 1);
        chk({name, " busy_cycles"}, cyc, 2 * BOARD_H + m_moved + m_cleared + 1);
        chk({name, " done_pulses"}, dn, 1);
        chk({name, " rd_wr_overlap"}, both, 0);
        chk({name, " lines_cleared"}, lc, m_cleared);
        repeat (3) @(negedge Clk);
        chk({name, " busy_idle"}, busy, 0);
        chk({name, " lines_cleared_held"}, lines_cleared, m_cleared);
        chk({name, " total_lines"}, total_lines, m_total);
        chk({name, " level"}, level, (m_total / 10 > 15) ? 15 : m_total / 10);
        for (int r = 0; r < BOARD_H; r++)
            chk($sformatf("%s row%0d", name, r), mem[r], exp_img[r]);
    endtask

    initial begin
        for (int r = 0; r < BOARD_H; r++) img[r] = '0;
        repeat (2) @(negedge Clk);
        chk("reset_outputs", {busy, done, row_rd_en, row_wr_en, row_addr, row_wdata,
                              lines_cleared, total_lines, level}, 0);
        Reset_n = 1'b1;

        load_board();
        run_pass("empty", 0);

        for (int r = 0; r < BOARD_H; r++) img[r] = '0;
        img[19] = FULL; img[18] = 10'h001;
        load_board();
        run_pass("one_line", 0);

        for (int r = 0; r < BOARD_H; r++) img[r] = '0;
        img[19] = FULL; img[18] = FULL; img[17] = 10'h2AA;
        load_board();
        run_pass("two_lines", 0);

        for (int r = 0; r < BOARD_H; r++) img[r] = rand_row(0);
        img[5] = FULL; img[15] = FULL;
        load_board();
        run_pass("rows_5_15", 0);

        // Reset while a moved row is being written
        for (int r = 0; r < BOARD_H; r++) img[r] = rand_row(0) | 10'h100;
        img[19] = FULL;
        load_board();
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        begin
            int g;
            g = 0;
            while (!(row_wr_en && row_wdata != '0) && g < 100) begin @(negedge Clk); g++; end
            chk("wr_reached", g < 100, 1);
        end
        Reset_n = 1'b0;
        #1;
        chk("reset_mid_wr", {busy, done, row_rd_en, row_wr_en, row_addr, row_wdata,
                             lines_cleared, total_lines, level}, 0);
        @(negedge Clk); Reset_n = 1'b1;
        m_total = 0;
        @(negedge Clk);
        chk("idle_after_reset", busy, 0);

        // Ten single-line passes: level steps on the tenth
        for (int p = 0; p < 10; p++) begin
            for (int r = 0; r < BOARD_H; r++) img[r] = rand_row(0);
            img[$urandom_range(BOARD_H - 1)] = FULL;
            load_board();
            run_pass($sformatf("single%0d", p), 0);
        end

        for (int p = 0; p < 12; p++) begin
            for (int r = 0; r < BOARD_H; r++) img[r] = rand_row(int'($urandom_range(60)));
            load_board();
            run_pass($sformatf("rand%0d", p), p == 3);
        end

        // Full boards push the level into saturation
        for (int p = 0; p < 9; p++) begin
            for (int r = 0; r < BOARD_H; r++) img[r] = FULL;
            load_board();
            run_pass($sformatf("full%0d", p), 0);
        end
        chk("level_saturated", level, 15);

        for (int r = 0; r < BOARD_H; r++) img[r] = rand_row(30);
        load_board();
        run_pass("held_start", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
